// File: rtl/cu_pkg.sv
// Shared types for the CU CTA dispatcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cu_pkg;

    // Default bound on issued-but-not-completed CTAs.
    localparam int CU_MAX_INFLIGHT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } cu_dispatch_st_e;

    // One CTA descriptor as presented to the scheduler.
    typedef struct packed {
        logic [31:0] id_x;
        logic [31:0] id_y;
        logic [31:0] id_z;
        logic [11:0] ntid_x;
        logic [11:0] ntid_y;
        logic [5:0]  ntid_z;
        logic [31:0] pc;
        logic        last;
    } cu_cta_desc_t;

endpackage

// File: rtl/cu_cta_idx_cnt.sv
// 3-D CTA index counter: x fastest, then y, then z; load zeroes all indices.
// Latency: index updates on the clock after load/adv; last is combinational.
// Backpressure: none; caller asserts adv only on an accepted descriptor.
// Ports: clk, rst_n, clear, load, adv, dim_x/y/z (grid dims, held stable while
//        counting), idx_x/y/z (current coordinates), last (final grid point).
module cu_cta_idx_cnt
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] dim_x,
    input  logic [31:0] dim_y,
    input  logic [31:0] dim_z,
    output logic [31:0] idx_x,
    output logic [31:0] idx_y,
    output logic [31:0] idx_z,
    output logic        last
);

    logic [31:0] x_q, y_q, z_q;
    logic [31:0] x_d, y_d, z_d;
    logic        x_end, y_end, z_end;

    assign x_end = (x_q == dim_x - 32'd1);
    assign y_end = (y_q == dim_y - 32'd1);
    assign z_end = (z_q == dim_z - 32'd1);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (load) begin
            x_d = '0;
            y_d = '0;
            z_d = '0;
        end else if (adv) begin
            if (x_end) begin
                x_d = '0;
                if (y_end) begin
                    y_d = '0;
                    z_d = z_q + 32'd1;
                end else begin
                    y_d = y_q + 32'd1;
                end
            end else begin
                x_d = x_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (clear) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign idx_x = x_q;
    assign idx_y = y_q;
    assign idx_z = z_q;
    assign last  = x_end && y_end && z_end;

endmodule

// File: rtl/cu_cta_dispatch.sv
// Kernel-launch sequencer: snapshots config on start, issues one CTA descriptor per grid point.
// Latency: start at T -> first descriptor valid at T+1; last completion at N -> kernel_done at N+1.
// Backpressure: valid/ready toward scheduler; issue stalls while MAX_INFLIGHT CTAs are outstanding.
// Ports: clk/rst_n/clear, start_en/start + cfg_* (launch command), cta_* (descriptor
//        handshake out, cta_done completions in), busy/kernel_done/err_sticky (status).
module cu_cta_dispatch
    import cu_pkg::*;
#(
    parameter int MAX_INFLIGHT = CU_MAX_INFLIGHT,
    parameter int OW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        start_en,
    input  logic        start,
    input  logic [11:0] cfg_ntid_x,
    input  logic [11:0] cfg_ntid_y,
    input  logic [5:0]  cfg_ntid_z,
    input  logic [31:0] cfg_nctaid_x,
    input  logic [31:0] cfg_nctaid_y,
    input  logic [31:0] cfg_nctaid_z,
    input  logic [31:0] cfg_init_pc,
    output logic        cta_valid,
    input  logic        cta_ready,
    output logic [31:0] cta_id_x,
    output logic [31:0] cta_id_y,
    output logic [31:0] cta_id_z,
    output logic [11:0] cta_ntid_x,
    output logic [11:0] cta_ntid_y,
    output logic [5:0]  cta_ntid_z,
    output logic [31:0] cta_pc,
    output logic        cta_last,
    input  logic        cta_done,
    output logic        busy,
    output logic        kernel_done,
    output logic        err_sticky
);

    cu_dispatch_st_e state_q, state_d;
    logic [OW-1:0]   out_q, out_d;
    logic            err_q, err_d;

    logic [31:0] nx_q, ny_q, nz_q, pc_q;
    logic [11:0] tx_q, ty_q;
    logic [5:0]  tz_q;

    logic        start_req, start_acc, start_busy, cfg_zero;
    logic        hs, spurious;
    logic [31:0] idx_x, idx_y, idx_z;
    logic        idx_last;
    cu_cta_desc_t desc;

    assign start_req  = start_en && start;
    assign start_acc  = start_req && (state_q == ST_IDLE);
    assign start_busy = start_req && (state_q != ST_IDLE);
    assign cfg_zero   = (cfg_nctaid_x == '0) || (cfg_nctaid_y == '0) || (cfg_nctaid_z == '0) ||
                        (cfg_ntid_x == '0) || (cfg_ntid_y == '0) || (cfg_ntid_z == '0);
    assign hs         = cta_valid && cta_ready;
    assign spurious   = cta_done && !hs && (out_q == '0);

    // A simultaneous issue and completion cancel; a completion with nothing
    // outstanding is dropped (and flagged).
    always_comb begin
        out_d = out_q;
        if (hs && !cta_done) begin
            out_d = out_q + OW'(1);
        end else if (!hs && cta_done && (out_q != '0)) begin
            out_d = out_q - OW'(1);
        end
    end

    // An accepted start clears old errors but a same-cycle spurious completion still sticks.
    assign err_d = (start_acc ? 1'b0 : err_q) | spurious | start_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Configuration snapshot: the CSR inputs may change freely once a kernel is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_q <= '0; ny_q <= '0; nz_q <= '0; pc_q <= '0;
            tx_q <= '0; ty_q <= '0; tz_q <= '0;
        end else if (clear) begin
            nx_q <= '0; ny_q <= '0; nz_q <= '0; pc_q <= '0;
            tx_q <= '0; ty_q <= '0; tz_q <= '0;
        end else if (start_acc) begin
            nx_q <= cfg_nctaid_x;
            ny_q <= cfg_nctaid_y;
            nz_q <= cfg_nctaid_z;
            pc_q <= cfg_init_pc;
            tx_q <= cfg_ntid_x;
            ty_q <= cfg_ntid_y;
            tz_q <= cfg_ntid_z;
        end
    end

    // The counter is not advanced past the last point so it holds the final id.
    cu_cta_idx_cnt u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .load  (start_acc),
        .adv   (hs && !idx_last),
        .dim_x (nx_q),
        .dim_y (ny_q),
        .dim_z (nz_q),
        .idx_x (idx_x),
        .idx_y (idx_y),
        .idx_z (idx_z),
        .last  (idx_last)
    );

    // Next-state logic. DRAIN looks at the next outstanding count so the final
    // completion is answered with kernel_done one cycle later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_acc) state_d = cfg_zero ? ST_DONE : ST_LAUNCH;
            ST_LAUNCH: if (hs && idx_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (out_d == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs. Issue is throttled on the registered count only.
    always_comb begin
        cta_valid   = (state_q == ST_LAUNCH) && (out_q < OW'(MAX_INFLIGHT));
        busy        = (state_q != ST_IDLE);
        kernel_done = (state_q == ST_DONE);
    end

    always_comb begin
        desc        = '0;
        desc.id_x   = idx_x;
        desc.id_y   = idx_y;
        desc.id_z   = idx_z;
        desc.ntid_x = tx_q;
        desc.ntid_y = ty_q;
        desc.ntid_z = tz_q;
        desc.pc     = pc_q;
        desc.last   = idx_last && (state_q == ST_LAUNCH);
    end

    assign cta_id_x   = desc.id_x;
    assign cta_id_y   = desc.id_y;
    assign cta_id_z   = desc.id_z;
    assign cta_ntid_x = desc.ntid_x;
    assign cta_ntid_y = desc.ntid_y;
    assign cta_ntid_z = desc.ntid_z;
    assign cta_pc     = desc.pc;
    assign cta_last   = desc.last;
    assign err_sticky = err_q;

endmodule

// File: doc/cu_cta_dispatch.md
# cu_cta_dispatch

Kernel-launch sequencer sitting directly downstream of the CU CSR slave. On a kernel-start command it snapshots the grid/block/PC configuration registers and issues one CTA descriptor per grid point over a valid/ready handshake to the CU scheduler. It bounds in-flight CTAs, counts completions, and signals kernel completion.

## Interface
- MAX_INFLIGHT, 8: maximum issued-but-not-completed CTAs (power of 2, ≥1)
- OW, $clog2(MAX_INFLIGHT+1): outstanding-counter width
---
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous soft reset, same effect as rst_n
- start_en  in  1  from cu_cmd_kernel_startOEn
- start  in  1  from cu_cmd_kernel_startO; accepted when start_en&&start
- cfg_ntid_x/y  in  12 each; cfg_ntid_z  in  6  threads per CTA
- cfg_nctaid_x/y/z  in  32 each  grid dimensions
- cfg_init_pc  in  32  kernel entry PC
- cta_valid  out  1  descriptor valid
- cta_ready  in  1  scheduler accepts
- cta_id_x/y/z  out  32 each  CTA coordinates
- cta_ntid_x/y/z  out  12/12/6  snapshotted block dims
- cta_pc  out  32  snapshotted init PC
- cta_last  out  1  final CTA of grid
- cta_done  in  1  one-cycle pulse per completed CTA
- busy  out  1  kernel in progress
- kernel_done  out  1  one-cycle pulse at kernel completion
- err_sticky  out  1  start-while-busy or spurious cta_done; cleared by next accepted start

## Operation
- Reset/clear values: all outputs 0, state IDLE, outstanding 0.
- States: IDLE, LAUNCH, DRAIN, DONE.
- IDLE: accepted start snapshots all cfg_* inputs → LAUNCH; if any nctaid or ntid field is 0 → DONE directly (no CTAs issued).
- LAUNCH: cta_valid=1 while outstanding<MAX_INFLIGHT; handshake = cta_valid&&cta_ready. Per handshake, index advances x fastest, then y, then z (x wraps nctaid_x-1→0 and increments y; y wraps and increments z). Handshake with cta_last=1 → DRAIN.
- cta_last = (x==nx-1)&&(y==ny-1)&&(z==nz-1); no grid-size product computed.
- Payload stable while cta_valid&&!cta_ready; cta_valid never drops without handshake except on reset/clear.
- Outstanding: +1 on handshake, −1 on cta_done, unchanged when both same cycle. cta_done with outstanding==0 (and no same-cycle handshake) ignored, sets err_sticky.
- DRAIN: outstanding==0 → DONE.
- DONE: kernel_done=1 for exactly one cycle → IDLE.
- busy=1 in LAUNCH, DRAIN, DONE.
- Start while busy ignored, sets err_sticky.
- Reset/clear mid-kernel: immediate return to IDLE, no kernel_done, in-flight CTAs forgotten.

## Timing
- Start accepted cycle T → busy and cta_valid high at T+1 with id (0,0,0).
- ready held high, not throttled: one CTA per cycle.
- At outstanding==MAX_INFLIGHT, cta_valid low the following cycle; reasserts cycle after outstanding drops.
- Throttle uses registered outstanding; same-cycle cta_done does not unblock issue.
- Last completion in cycle N (DRAIN) → kernel_done at N+1, busy low at N+2.
- Zero-dimension start at T → kernel_done at T+1.

## Structure
- cu_pkg: state enum cu_dispatch_st_e, descriptor struct cu_cta_desc_t (ids, ntid, pc, last), default MAX_INFLIGHT.
- Sub-module cu_cta_idx_cnt: 3-D wrap counter with load/advance inputs and last output.

## Test plan
- Grid 2×2×1, ntid 32×1×1, pc 0x100, ready=1, immediate completions → ids (0,0,0),(1,0,0),(0,1,0),(1,1,0), cta_last on 4th, one kernel_done.
- Grid 20×1×1, cta_done withheld → exactly 8 handshakes, cta_valid low; one cta_done → one more CTA issued.
- cta_ready toggled randomly → payload stable whenever valid&&!ready; sequence in order.
- nctaid_y=0 start → kernel_done at T+1, no cta_valid.
- Start while busy and spurious cta_done in IDLE → ignored, err_sticky=1; next valid start clears it.
- clear asserted mid-LAUNCH → busy/cta_valid 0 next cycle, no kernel_done; new start restarts from (0,0,0).
